ascii_uart_tx: RTL

Downstream consumer of the 3-character ASCII number field (24-bit, MS character in [23:16], leading blanks already encoded as 0x20). On a start pulse it latches the field and serialises it as 8N1 UART frames on a single TX line, MS character first. It optionally appends CR LF so each reading lands on its own terminal line. It provides the busy/done handshake for the top-level sampler that triggers transmissions.

---
 rtl/ascii_uart_tx.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx: serialises a latched 3-character ASCII field as 8N1 UART
// frames, MS character first, optionally followed by CR LF. Provides the
// busy/done handshake for the sampler that triggers each transmission.
module ascii_uart_tx #(
  parameter int CLK_FREQ    = 100000000,
  parameter int BAUD        = 115200,
  parameter int APPEND_CRLF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] ascii,
  input  logic        send,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(CPB - 1);
  localparam logic [2:0]    LAST_BYTE = (APPEND_CRLF != 0) ? 3'd4 : 3'd2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [2:0]    byte_idx, byte_n;
  logic [23:0]   hold, hold_n;
  logic          tx_n, busy_n, done_n;
  logic [7:0]    cur_byte;
  logic          bit_end;

  assign bit_end = (cnt == CNT_MAX);

  // Byte currently on the line: three held characters, then CR, LF.
  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx)
      3'd0:    cur_byte = hold[23:16];
      3'd1:    cur_byte = hold[15:8];
      3'd2:    cur_byte = hold[7:0];
      3'd3:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  // Next state and next registered outputs; tx/busy/done are computed one
  // step ahead so they come straight out of flops.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    hold_n  = hold;
    tx_n    = tx;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (send) begin
          hold_n  = ascii;
          byte_n  = 3'd0;
          cnt_n   = '0;
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          bit_n   = 3'd0;
          state_n = DATA;
          tx_n    = cur_byte[0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_idx + 3'd1;
            tx_n  = cur_byte[bit_idx + 3'd1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (byte_idx == LAST_BYTE) begin
            // Line complete; a send in the done cycle is taken from IDLE.
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            tx_n    = 1'b1;
          end else begin
            // Next frame starts immediately, no extra idle bit.
            byte_n  = byte_idx + 3'd1;
            state_n = START;
            tx_n    = 1'b0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset; reset abandons any
  // partial line without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 3'd0;
      hold     <= 24'h0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      hold     <= hold_n;
      tx       <= tx_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule
